// File: rtl/generic_mem_req_adapter.sv
// generic_mem_req_adapter: valid/ready request front end for a 1-cycle-latency memory with a credit-limited response FIFO
module generic_mem_req_adapter #(
    parameter type         T         = logic [31:0],
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [7:0] req_addr,
    input  T           req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output T           rsp_data,
    output logic [7:0] mem_addr,
    output T           mem_write_data,
    output logic       mem_write_en,
    input  T           mem_read_data
);
    localparam int unsigned AW = $clog2(RSP_DEPTH);
    localparam int unsigned CW = AW + 1;

    T              buf_q [RSP_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   used;
    logic          pend_q, pop, acc;

    assign rsp_valid      = cnt_q != '0;
    assign rsp_data       = buf_q[rptr_q];
    assign mem_addr       = req_addr;
    assign mem_write_data = req_wdata;

    // Reads need a credit: stored + in-flight responses, less this cycle's pop, must leave a free slot
    always_comb begin
        pop          = rsp_valid && rsp_ready;
        used         = (CW+1)'(cnt_q) + (CW+1)'(pend_q) - (CW+1)'(pop);
        req_ready    = !rst && (req_we || used < (CW+1)'(RSP_DEPTH));
        acc          = req_valid && req_ready;
        mem_write_en = acc && req_we;
        cnt_d        = cnt_q + CW'(pend_q) - CW'(pop);
    end

    // Pending marks a read whose datum lands on mem_read_data next cycle; it is pushed then
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            pend_q <= acc && !req_we;
            cnt_q  <= cnt_d;
            if (pend_q) wptr_q <= wptr_q + AW'(1);
            if (pop) rptr_q <= rptr_q + AW'(1);
        end
    end

    // Response storage needs no reset; the count alone decides which entries are valid
    always_ff @(posedge clk) begin
        if (pend_q && !rst) buf_q[wptr_q] <= mem_read_data;
    end
endmodule

// File: tb/tb_generic_mem_req_adapter.sv
// tb_generic_mem_req_adapter: directed stimulus checked against a queue-based response model every cycle
module tb_generic_mem_req_adapter;
    localparam int D = 2;

    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_we = 0, rsp_ready = 0;
    logic [7:0]  req_addr = 0;
    logic [31:0] req_wdata = 0;
    logic        req_ready, rsp_valid, mem_write_en;
    logic [31:0] rsp_data, mem_write_data, mem_read_data;
    logic [7:0]  mem_addr;

    generic_mem_req_adapter #(.T(logic [31:0]), .RSP_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read_data(mem_read_data));

    logic        b_req_valid = 0, b_req_we = 0, b_rsp_ready = 0;
    logic [7:0]  b_req_addr = 0;
    logic [63:0] b_req_wdata = 0;
    logic        b_req_ready, b_rsp_valid, b_mem_write_en;
    logic [63:0] b_rsp_data, b_mem_write_data, b_mem_read_data;
    logic [7:0]  b_mem_addr;

    generic_mem_req_adapter #(.T(logic [63:0]), .RSP_DEPTH(D)) dut64 (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_data(b_rsp_data), .mem_addr(b_mem_addr), .mem_write_data(b_mem_write_data),
        .mem_write_en(b_mem_write_en), .mem_read_data(b_mem_read_data));

    // Attached memories: registered read, 1-cycle latency
    logic [31:0] ram [256];
    logic [63:0] ram64 [256];
    always @(posedge clk) begin
        if (mem_write_en) ram[mem_addr] <= mem_write_data;
        mem_read_data <= ram[mem_addr];
        if (b_mem_write_en) ram64[b_mem_addr] <= b_mem_write_data;
        b_mem_read_data <= ram64[b_mem_addr];
    end

    int checks = 0, failures = 0;
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: every accepted read becomes an entry visible two cycles later, removed when consumed
    typedef struct {logic [31:0] d; int rdy;} ent_t;
    ent_t        q[$];
    logic [31:0] mmem [256];
    int          cyc = 0;
    bit          chk_en = 0;
    logic [31:0] got[$];
    int          got_cyc[$];

    function automatic bit m_valid();
        return q.size() > 0 && q[0].rdy <= cyc;
    endfunction
    function automatic bit m_pop();
        return m_valid() && rsp_ready;
    endfunction
    function automatic bit m_ready();
        return !rst && (req_we || (q.size() - int'(m_pop())) < D);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", req_ready, m_ready());
            chk("mem_write_en", mem_write_en, req_valid && m_ready() && req_we);
            chk("mem_addr", mem_addr, req_addr);
            chk("mem_write_data", mem_write_data, req_wdata);
            chk("rsp_valid", rsp_valid, m_valid());
            if (m_valid()) chk("rsp_data", rsp_data, q[0].d);
            if (rsp_valid && rsp_ready) begin
                got.push_back(rsp_data);
                got_cyc.push_back(cyc);
            end
        end
    end

    always @(posedge clk) begin
        bit p, a;
        p = m_pop();
        a = req_valid && m_ready();
        if (rst) begin
            q.delete();
            chk_en = 1;
        end else begin
            if (p) void'(q.pop_front());
            if (a && req_we) mmem[req_addr] = req_wdata;
            else if (a) q.push_back('{mmem[req_addr], cyc + 2});
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(bit v, bit we, logic [7:0] a, logic [31:0] wd);
        req_valid = v;
        req_we = we;
        req_addr = a;
        req_wdata = wd;
        #1;
    endtask

    initial begin
        rst = 1;
        step();
        drive(1, 1, 8'h10, 32'h1);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mem_we", mem_write_en, 0);
        step();
        rst = 0;
        drive(0, 0, 0, 0);
        chk("rst_rsp_valid", rsp_valid, 0);

        drive(1, 1, 8'h10, 32'hDEADBEEF);
        chk("t1_wr_ready", req_ready, 1);
        step();
        drive(1, 0, 8'h10, 0);
        chk("t1_rd_ready", req_ready, 1);
        step();
        drive(0, 0, 0, 0);
        chk("t1_lat1_valid", rsp_valid, 0);
        step();
        chk("t1_lat2_valid", rsp_valid, 1);
        chk("t1_data", rsp_data, 32'hDEADBEEF);
        rsp_ready = 1;
        step();
        chk("t1_popped", rsp_valid, 0);

        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 8'(i), 32'h100 + 32'(i));
            step();
        end
        got.delete();
        got_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 8'(i), 0);
            chk("t2_ready", req_ready, 1);
            step();
        end
        drive(0, 0, 0, 0);
        repeat (4) step();
        chk("t2_count", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++) begin
            chk("t2_data", got[i], 32'h100 + 32'(i));
            if (i > 0) chk("t2_consecutive", got_cyc[i] - got_cyc[i-1], 1);
        end

        rsp_ready = 0;
        got.delete();
        drive(1, 0, 0, 0);
        chk("t3_rd0_ready", req_ready, 1);
        step();
        drive(1, 0, 1, 0);
        chk("t3_rd1_ready", req_ready, 1);
        step();
        drive(1, 0, 2, 0);
        chk("t3_rd2_blocked", req_ready, 0);
        step();
        chk("t3_rd2_blocked2", req_ready, 0);
        step();
        drive(1, 1, 8'h20, 32'h55AA55AA);
        chk("t3_wr_ready_full", req_ready, 1);
        chk("t3_wr_en_full", mem_write_en, 1);
        step();
        drive(1, 0, 2, 0);
        chk("t3_rd2_blocked3", req_ready, 0);
        chk("t3_head_valid", rsp_valid, 1);
        chk("t3_head_data", rsp_data, 32'h100);
        rsp_ready = 1;
        #1;
        chk("t3_rd2_on_pop", req_ready, 1);
        step();
        drive(0, 0, 0, 0);
        repeat (4) step();
        chk("t3_count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("t3_data", got[i], 32'h100 + 32'(i));

        rsp_ready = 0;
        got.delete();
        drive(1, 0, 3, 0);
        step();
        drive(1, 0, 4, 0);
        step();
        drive(0, 0, 0, 0);
        chk("t4_pre_valid", rsp_valid, 1);
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("t4_post_valid", rsp_valid, 0);
        step();
        chk("t4_post_valid2", rsp_valid, 0);
        rsp_ready = 1;
        repeat (3) step();
        chk("t4_no_stale", got.size(), 0);
        drive(1, 0, 5, 0);
        chk("t4_rd_ready", req_ready, 1);
        step();
        drive(0, 0, 0, 0);
        repeat (3) step();
        chk("t4_count", got.size(), 1);
        if (got.size() > 0) chk("t4_data", got[0], 32'h105);

        b_req_valid = 1;
        b_req_we = 1;
        b_req_addr = 8'hFF;
        b_req_wdata = 64'h0123456789ABCDEF;
        #1;
        chk("t5_wr_ready", b_req_ready, 1);
        chk("t5_wr_en", b_mem_write_en, 1);
        chk("t5_addr", b_mem_addr, 8'hFF);
        step();
        b_req_we = 0;
        #1;
        chk("t5_rd_ready", b_req_ready, 1);
        step();
        b_req_valid = 0;
        step();
        chk("t5_valid", b_rsp_valid, 1);
        chk("t5_data", b_rsp_data, 64'h0123456789ABCDEF);
        b_rsp_ready = 1;
        step();
        chk("t5_popped", b_rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
